// File: rtl/comparator_serial.sv
// Bit-serial MSB-first magnitude comparator with cascade inputs and start/busy/done handshake.
// Optional CMP_EARLY_EXIT_EN: leave the compare loop as soon as the outcome is known.
module comparator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l,
  input  logic             g,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic             dec_gt;
  logic             dec_lt;

  logic bit_gt;
  logic bit_lt;
  logic res_gt;
  logic res_lt;
  logic exit_now;

  // Cascade-equal is implied when neither g nor l is set, so q carries no extra information.
  logic cascade_unused;
  assign cascade_unused = q;

  always_comb begin
    bit_gt = 1'b0;
    bit_lt = 1'b0;
    bit_gt = a_r[idx] & ~b_r[idx];
    bit_lt = ~a_r[idx] & b_r[idx];
    // The first deciding source (cascade or a higher bit) wins; later bits only fill an undecided result.
    res_gt = dec_gt | (~dec_lt & bit_gt);
    res_lt = dec_lt | (~dec_gt & bit_lt);
`ifdef CMP_EARLY_EXIT_EN
    exit_now = (idx == '0) | bit_gt | bit_lt;
`else
    exit_now = (idx == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      idx    <= '0;
      dec_gt <= 1'b0;
      dec_lt <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lt     <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            idx    <= IDX_MSB;
            dec_gt <= g;
            dec_lt <= ~g & l;
`ifdef CMP_EARLY_EXIT_EN
            if (g | l) begin
              state <= DONE;
              done  <= 1'b1;
              gt    <= g;
              lt    <= ~g & l;
              eq    <= 1'b0;
            end else begin
              state <= CMP;
              busy  <= 1'b1;
            end
`else
            state <= CMP;
            busy  <= 1'b1;
`endif
          end
        end
        CMP: begin
          dec_gt <= res_gt;
          dec_lt <= res_lt;
          if (exit_now) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            gt    <= res_gt;
            lt    <= res_lt;
            eq    <= ~res_gt & ~res_lt;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_serial.sv
// Bench for comparator_serial: latency/result model checked every cycle plus hand-computed vectors.
module tb_comparator_serial;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         l = 1'b0;
  logic         g = 1'b0;
  logic         q = 1'b0;
  logic         busy, done, lt, eq, gt;

  int tests = 0;
  int fails = 0;

  comparator_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .l(l), .g(g), .q(q),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Result code {lt,eq,gt}
  function automatic logic [2:0] model_res(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic lv, input logic gv);
    if (gv) return 3'b001;
    if (lv) return 3'b100;
    if (av > bv) return 3'b001;
    if (av < bv) return 3'b100;
    return 3'b010;
  endfunction

  // Cycles from accept edge to the done cycle
  function automatic int model_lat(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic lv, input logic gv);
`ifdef CMP_EARLY_EXIT_EN
    if (gv || lv) return 1;
    for (int i = W - 1; i >= 0; i--)
      if (av[i] != bv[i]) return 1 + (W - i);
    return 1 + W;
`else
    return W + 1;
`endif
  endfunction

  int         m_cnt;
  logic       exp_busy, exp_done;
  logic [2:0] exp_res, m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; exp_busy = 0; exp_done = 0; exp_res = 3'b000; m_pend = 3'b000;
    end else begin
      if (exp_done) exp_done = 0;
      else if (m_cnt == 0 && start) begin
        m_cnt  = model_lat(a, b, l, g);
        m_pend = model_res(a, b, l, g);
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          exp_done = 1; exp_busy = 0; exp_res = m_pend;
        end else exp_busy = 1;
      end
    end
  end

  logic check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("cyc busy", int'(busy), int'(exp_busy));
      chk("cyc done", int'(done), int'(exp_done));
      chk("cyc res", int'({lt, eq, gt}), int'(exp_res));
      if (busy && done) chk("busy/done overlap", 1, 0);
    end
  end

  task automatic wait_done(input int bound, output int n);
    int k;
    k = 0; n = -1;
    while (k < bound && n < 0) begin
      @(negedge clk);
      k++;
      if (done) n = k;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic lv, input logic gv, input logic qv,
                        input int exp_lat, input logic [2:0] exp_r);
    int n;
    @(posedge clk); #1;
    a = av; b = bv; l = lv; g = gv; q = qv; start = 1;
    @(posedge clk); #1;
    start = 0; a = W'($urandom); b = W'($urandom); l = 1'($urandom); g = 1'($urandom); q = 0;
    wait_done(40, n);
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " result"}, int'({lt, eq, gt}), int'(exp_r));
  endtask

  initial begin
    int n;
    #12;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset lt/eq/gt", int'({lt, eq, gt}), 0);
    @(posedge clk); #1;
    rst = 0;
    check_en = 1;
    repeat (2) @(posedge clk);
    chk("idle lt/eq/gt", int'({lt, eq, gt}), 0);

`ifdef CMP_EARLY_EXIT_EN
    run_op("T1", 8'h5A, 8'h5A, 0, 0, 1, 9, 3'b010);
    run_op("T2", 8'h80, 8'h7F, 0, 0, 1, 2, 3'b001);
    run_op("T3", 8'h01, 8'h02, 0, 0, 1, 8, 3'b100);
    run_op("T4", 8'h00, 8'hFF, 1, 1, 0, 1, 3'b001);
    run_op("Tl", 8'hFF, 8'h00, 1, 0, 0, 1, 3'b100);
`else
    run_op("T1", 8'h5A, 8'h5A, 0, 0, 1, 9, 3'b010);
    run_op("T2", 8'h80, 8'h7F, 0, 0, 1, 9, 3'b001);
    run_op("T3", 8'h01, 8'h02, 0, 0, 1, 9, 3'b100);
    run_op("T4", 8'h00, 8'hFF, 1, 1, 0, 9, 3'b001);
    run_op("Tl", 8'hFF, 8'h00, 1, 0, 0, 9, 3'b100);
`endif
    run_op("Tlsb", 8'hFE, 8'hFF, 0, 0, 1, model_lat(8'hFE, 8'hFF, 0, 0), 3'b100);
    run_op("Tnoq", 8'h33, 8'h33, 0, 0, 0, W + 1, 3'b010);

    // T5: start held high; second operands only accepted after first done
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20; l = 0; g = 0; q = 1; start = 1;
    @(posedge clk); #1;
    a = 8'd3; b = 8'd3;
    wait_done(40, n);
    chk("T5 first result", int'({lt, eq, gt}), 3'b100);
    wait_done(40, n);
    chk("T5 second gap", n, 10);
    chk("T5 second result", int'({lt, eq, gt}), 3'b010);
    @(posedge clk); #1;
    start = 0;
    repeat (12) @(posedge clk);

    // T6: async reset in cycle 4 of an op
    @(posedge clk); #1;
    a = 8'h5A; b = 8'h5A; q = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("T6 busy after rst", int'(busy), 0);
    chk("T6 done after rst", int'(done), 0);
    chk("T6 lt/eq/gt after rst", int'({lt, eq, gt}), 0);
    @(posedge clk); #1;
    rst = 0;
    wait_done(15, n);
    chk("T6 no done after abort", n, -1);
    run_op("T6 restart", 8'hC3, 8'hC4, 0, 0, 1, model_lat(8'hC3, 8'hC4, 0, 0), 3'b100);

    repeat (3) @(posedge clk);
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
